palette_lookup: RTL and testbench

Pixel-pipeline stage that converts 11-bit palette indices into RGB888. It sits directly upstream of the vertical shrink stage and feeds it `r/g/b` together with sync and blank signals that are delay-matched to the colour. The palette RAM holds 2048 entries of xBGR555 and is written and read by the CPU through a req/ack port. A hardware clear sequence runs after reset.

---
 rtl/palette_pkg.sv | 32 +++
 rtl/palette_dpram.sv | 54 +++++
 rtl/palette_lookup.sv | 231 +++++++++++++++++++++++
 tb/tb_palette_lookup.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and helpers for the palette lookup stage.
package palette_pkg;

    // Palette entry layout as stored in RAM (xBGR555).
    typedef struct packed {
        logic       unused;
        logic [4:0] b5;
        logic [4:0] g5;
        logic [4:0] r5;
    } pal_entry_t;

    // CPU-side sequencer states.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        ACK   = 2'd2
    } pal_state_t;

    localparam int         ENTRY_W     = 16;
    localparam int         CHAN_W      = 5;
    localparam int         R_LSB       = 0;
    localparam int         G_LSB       = 5;
    localparam int         B_LSB       = 10;
    localparam pal_entry_t CLEAR_ENTRY = '0;

    // 5-bit channel to 8-bit by replicating the top bits into the LSBs,
    // so full scale maps to 0xFF and zero stays zero.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/palette_dpram.sv
// True dual-port palette RAM, 2^ADDR_W x 16.
// Port A: video read. Port B: CPU/clear read-modify with byte enables.
// Both ports have one clock of read latency; a read on either port in the
// same cycle as a port-B write to that address returns the old contents.
module palette_dpram
    import palette_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic                 clk,
    // Port A: video never uses the spare bit 15, so it only carries colour
    input  logic                 a_en,
    input  logic [ADDR_W-1:0]    a_addr,
    output logic [ENTRY_W-2:0]   a_dout,
    // Port B
    input  logic                 b_en,
    input  logic                 b_we,
    input  logic [1:0]           b_be,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [ENTRY_W-1:0]   b_din,
    output logic [ENTRY_W-1:0]   b_dout
);

    localparam int DEPTH = 1 << ADDR_W;

    (* ramstyle = "no_rw_check" *) logic [ENTRY_W-1:0] mem [DEPTH];

    logic [ENTRY_W-2:0] a_dout_q;
    logic [ENTRY_W-1:0] b_dout_q;

    // Port A registered read; old data on collision falls out of NBA ordering
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout_q <= mem[a_addr][ENTRY_W-2:0];
        end
    end

    // Port B registered read of pre-write contents plus byte-enabled write
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_dout_q <= mem[b_addr];
            if (b_we && b_be[0]) begin
                mem[b_addr][7:0] <= b_din[7:0];
            end
            if (b_we && b_be[1]) begin
                mem[b_addr][15:8] <= b_din[15:8];
            end
        end
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule

// File: rtl/palette_lookup.sv
// Palette lookup: 11-bit index -> RGB888 with delay-matched timing.
// Video path advances on ce_pix (2 stages); the CPU/clear sequencer runs
// every clk and owns RAM port B.
module palette_lookup #(
    parameter int IDX_W          = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hb_in,
    input  logic             vb_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic             hs_out,
    output logic             vs_out,
    output logic             hb_out,
    output logic             vb_out,
    output logic [7:0]       r_out,
    output logic [7:0]       g_out,
    output logic [7:0]       b_out,
    input  logic [IDX_W-1:0] cpu_addr,
    input  logic [15:0]      cpu_din,
    input  logic [1:0]       cpu_be,
    input  logic             cpu_we,
    input  logic             cpu_req,
    output logic             cpu_ack,
    output logic [15:0]      cpu_dout,
    output logic             busy
);

    import palette_pkg::*;

    localparam logic [IDX_W-1:0] CLR_LAST = '1;
    localparam pal_state_t       RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [ENTRY_W-2:0] ram_a_dout;
    logic               ram_b_en;
    logic               ram_b_we;
    logic [1:0]         ram_b_be;
    logic [IDX_W-1:0]   ram_b_addr;
    logic [ENTRY_W-1:0] ram_b_din;
    logic [ENTRY_W-1:0] ram_b_dout;

    palette_dpram #(
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk    (clk),
        .a_en   (ce_pix),
        .a_addr (idx_in),
        .a_dout (ram_a_dout),
        .b_en   (ram_b_en),
        .b_we   (ram_b_we),
        .b_be   (ram_b_be),
        .b_addr (ram_b_addr),
        .b_din  (ram_b_din),
        .b_dout (ram_b_dout)
    );

    // ------------------------------------------------------------------
    // CPU / clear sequencer
    // ------------------------------------------------------------------
    pal_state_t       state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic [15:0]      dout_q, dout_d;

    // Next-state and port-B drive. IDLE ignores a request while the ack of
    // the previous access is still visible, so a held req cannot re-trigger.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        dout_d     = dout_q;
        ram_b_en   = 1'b0;
        ram_b_we   = 1'b0;
        ram_b_be   = 2'b00;
        ram_b_addr = cpu_addr;
        ram_b_din  = cpu_din;
        case (state_q)
            CLEAR: begin
                ram_b_en   = 1'b1;
                ram_b_we   = 1'b1;
                ram_b_be   = 2'b11;
                ram_b_addr = clr_cnt_q;
                ram_b_din  = CLEAR_ENTRY;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (cpu_req && !ack_q) begin
                    ram_b_en = 1'b1;
                    ram_b_we = cpu_we;
                    ram_b_be = cpu_be;
                    state_d  = ACK;
                end
            end
            ACK: begin
                ack_d   = 1'b1;
                dout_d  = ram_b_dout;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An access launched in a reset cycle would never be acked
        if (reset) begin
            ram_b_en = 1'b0;
        end
    end

    // Sequencer state and registered CPU outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            busy_q    <= CLEAR_ON_RESET;
            ack_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
        end
    end

    // ------------------------------------------------------------------
    // Video pipeline
    // ------------------------------------------------------------------
    // Stage 1 holds timing alongside the RAM read; kill1 marks a stage-1
    // word read while the palette was being cleared (or straight out of
    // reset), whose RAM data must not reach the output.
    logic hs1_q, hs1_d, vs1_q, vs1_d, hb1_q, hb1_d, vb1_q, vb1_d;
    logic kill1_q, kill1_d;
    logic hs2_q, hs2_d, vs2_q, vs2_d, hb2_q, hb2_d, vb2_q, vb2_d;
    logic [7:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic       blank1;

    assign blank1 = hb1_q | vb1_q | kill1_q | busy_q;

    // Both stages step together on ce_pix and hold otherwise
    always_comb begin
        hs1_d   = hs1_q;
        vs1_d   = vs1_q;
        hb1_d   = hb1_q;
        vb1_d   = vb1_q;
        kill1_d = kill1_q;
        hs2_d   = hs2_q;
        vs2_d   = vs2_q;
        hb2_d   = hb2_q;
        vb2_d   = vb2_q;
        r2_d    = r2_q;
        g2_d    = g2_q;
        b2_d    = b2_q;
        if (ce_pix) begin
            hs1_d   = hs_in;
            vs1_d   = vs_in;
            hb1_d   = hb_in;
            vb1_d   = vb_in;
            kill1_d = busy_q;
            hs2_d   = hs1_q;
            vs2_d   = vs1_q;
            hb2_d   = hb1_q;
            vb2_d   = vb1_q;
            if (blank1) begin
                r2_d = 8'h00;
                g2_d = 8'h00;
                b2_d = 8'h00;
            end else begin
                r2_d = expand5(ram_a_dout[R_LSB +: CHAN_W]);
                g2_d = expand5(ram_a_dout[G_LSB +: CHAN_W]);
                b2_d = expand5(ram_a_dout[B_LSB +: CHAN_W]);
            end
        end
    end

    // Video pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            hb1_q   <= 1'b0;
            vb1_q   <= 1'b0;
            kill1_q <= 1'b1;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            hb2_q   <= 1'b0;
            vb2_q   <= 1'b0;
            r2_q    <= 8'h00;
            g2_q    <= 8'h00;
            b2_q    <= 8'h00;
        end else begin
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            hb1_q   <= hb1_d;
            vb1_q   <= vb1_d;
            kill1_q <= kill1_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            hb2_q   <= hb2_d;
            vb2_q   <= vb2_d;
            r2_q    <= r2_d;
            g2_q    <= g2_d;
            b2_q    <= b2_d;
        end
    end

    assign hs_out   = hs2_q;
    assign vs_out   = vs2_q;
    assign hb_out   = hb2_q;
    assign vb_out   = vb2_q;
    assign r_out    = r2_q;
    assign g_out    = g2_q;
    assign b_out    = b2_q;
    assign cpu_ack  = ack_q;
    assign cpu_dout = dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_palette_lookup.sv
// Scoreboard bench for palette_lookup: stimulus pushes expected CPU read
// data and expected video pixels; monitors pop and compare on cpu_ack and
// on ce_pix edges.
module tb_palette_lookup;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic        hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
    logic [10:0] idx_in = '0;
    logic        hs_out, vs_out, hb_out, vb_out;
    logic [7:0]  r_out, g_out, b_out;
    logic [10:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [1:0]  cpu_be = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_ack;
    logic [15:0] cpu_dout;
    logic        busy;

    always #5 clk = ~clk;

    palette_lookup #(.IDX_W(11), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .idx_in(idx_in),
        .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_be(cpu_be),
        .cpu_we(cpu_we), .cpu_req(cpu_req), .cpu_ack(cpu_ack),
        .cpu_dout(cpu_dout), .busy(busy)
    );

    typedef struct {
        int          tag;
        logic [3:0]  tim;   // {hs, vs, hb, vb}
        logic [23:0] rgb;
    } vid_exp_t;

    vid_exp_t    vq[$];
    logic [15:0] cq[$];
    vid_exp_t    mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ce_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Video monitor: output after ce edge k belongs to the pixel sampled at edge k-1
    always @(posedge clk) begin
        if (ce_pix && !reset) begin
            ce_cnt++;
            #1;
            while (vq.size() > 0 && vq[0].tag < ce_cnt - 1) begin
                check("video_missed_tag", vq[0].tag, ce_cnt - 1);
                void'(vq.pop_front());
            end
            if (vq.size() > 0 && vq[0].tag == ce_cnt - 1) begin
                mon_e = vq.pop_front();
                check("video_timing", {hs_out, vs_out, hb_out, vb_out}, mon_e.tim);
                check("video_rgb", {r_out, g_out, b_out}, mon_e.rgb);
            end
        end
    end

    // CPU monitor
    always @(negedge clk) begin
        if (cpu_ack) begin
            check("ack_while_busy", busy, 0);
            if (cq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: cpu_ack=1 with dout %0h but no access outstanding", cpu_dout);
            end else begin
                check("cpu_dout", cpu_dout, cq.pop_front());
            end
        end
    end

    task automatic pix(input logic [10:0] idx, input logic [3:0] tim, input bit chk,
                       input logic [23:0] rgb);
        vid_exp_t e;
        @(negedge clk);
        ce_pix = 1'b1;
        idx_in = idx;
        {hs_in, vs_in, hb_in, vb_in} = tim;
        if (chk) begin
            e.tag = ce_cnt + 1;
            e.tim = tim;
            e.rgb = rgb;
            vq.push_back(e);
        end
    endtask

    task automatic flush();
        repeat (2) pix(11'd0, 4'b0000, 1'b0, 24'h0);
        @(negedge clk);
        ce_pix = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [10:0] addr, input logic [15:0] din,
                              input logic [1:0] be, input logic [15:0] exp, input int exp_lat);
        int lat = 0;
        @(negedge clk);
        ce_pix = 1'b0;
        cq.push_back(exp);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_din = din;
        cpu_be = be;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 6000);
        cpu_req = 1'b0;
        check("cpu_ack_seen", cpu_ack, 1);
        if (!cpu_ack && cq.size() > 0) void'(cq.pop_back());
        if (exp_lat > 0) check("ack_latency", lat, exp_lat);
    endtask

    // Count cycles with busy high, starting at the current negedge
    task automatic wait_clear(input bit stream);
        int cnt = 0;
        int cyc = 0;
        vid_exp_t e;
        while (busy && cyc < 5000) begin
            cnt++;
            if (stream && cyc >= 100 && cyc < 106) begin
                ce_pix = 1'b1;
                idx_in = 11'(cyc);
                hs_in = cyc[0];
                e.tag = ce_cnt + 1;
                e.tim = {cyc[0], 3'b000};
                e.rgb = 24'h000000;
                vq.push_back(e);
            end else begin
                ce_pix = 1'b0;
                hs_in = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        ce_pix = 1'b0;
        hs_in = 1'b0;
        check("busy_cycles", cnt, 2048);
    endtask

    initial begin
        int lat;
        vid_exp_t e;

        // Reset, with timing inputs toggling to show outputs stay quiet
        reset = 1'b1;
        ce_pix = 1'b1;
        hs_in = 1'b1;
        vb_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rgb", {r_out, g_out, b_out}, 24'h0);
        check("rst_timing", {hs_out, vs_out, hb_out, vb_out}, 4'b0000);
        check("rst_ack", cpu_ack, 0);
        check("rst_dout", cpu_dout, 16'h0);
        check("rst_busy", busy, 1);

        // Release reset with a read of 0x7FF already pending during the clear
        @(negedge clk);
        reset = 1'b0;
        ce_pix = 1'b0;
        hs_in = 1'b0;
        vb_in = 1'b0;
        cq.push_back(16'h0000);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 11'h7FF;
        wait_clear(1'b1);
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("post_clear_ack", cpu_ack, 1);
        cpu_req = 1'b0;

        // White at index 5
        cpu_access(1'b1, 11'd5, 16'h7FFF, 2'b11, 16'h0000, 2);
        pix(11'd5, 4'b1000, 1'b1, 24'hFFFFFF);
        pix(11'd5, 4'b0100, 1'b1, 24'hFFFFFF);
        flush();

        // Byte-enabled writes to index 9
        cpu_access(1'b1, 11'd9, 16'h001F, 2'b01, 16'h0000, 2);
        cpu_access(1'b1, 11'd9, 16'h7C00, 2'b10, 16'h001F, 2);
        cpu_access(1'b0, 11'd9, 16'h0000, 2'b00, 16'h7C1F, 2);
        pix(11'd9, 4'b0000, 1'b1, 24'hFF00FF);
        flush();

        // Green at index 3 under blanking
        cpu_access(1'b1, 11'd3, 16'h03E0, 2'b11, 16'h0000, 2);
        pix(11'd3, 4'b0010, 1'b1, 24'h000000);
        pix(11'd3, 4'b0010, 1'b1, 24'h000000);
        pix(11'd3, 4'b0000, 1'b1, 24'h00FF00);
        pix(11'd3, 4'b0001, 1'b1, 24'h000000);
        pix(11'd3, 4'b0000, 1'b1, 24'h00FF00);
        flush();

        // Mid-scale channels, spare bit stored but not shown
        cpu_access(1'b1, 11'd12, 16'h8605, 2'b11, 16'h0000, 2);
        cpu_access(1'b0, 11'd12, 16'h0000, 2'b00, 16'h8605, 2);
        pix(11'd12, 4'b0000, 1'b1, 24'h298408);
        flush();

        // Collision: CPU write and video read of index 7 on the same edge
        @(negedge clk);
        cq.push_back(16'h0000);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 11'd7;
        cpu_din = 16'h001F;
        cpu_be = 2'b11;
        ce_pix = 1'b1;
        idx_in = 11'd7;
        {hs_in, vs_in, hb_in, vb_in} = 4'b0000;
        e.tag = ce_cnt + 1;
        e.tim = 4'b0000;
        e.rgb = 24'h000000;
        vq.push_back(e);
        @(negedge clk);
        lat = 1;
        e.tag = ce_cnt + 1;
        e.rgb = 24'hFF0000;
        vq.push_back(e);
        while (!cpu_ack && lat < 20) begin
            @(negedge clk);
            ce_pix = 1'b0;
            lat++;
        end
        cpu_req = 1'b0;
        check("collision_ack_latency", lat, 2);
        flush();

        // Reset while the sequencer sits in ACK
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 11'd5;
        @(negedge clk);
        check("pre_reset_no_ack", cpu_ack, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b0;
        check("reset_drops_ack", cpu_ack, 0);
        check("reset_busy_rises", busy, 1);
        wait_clear(1'b0);
        cpu_access(1'b0, 11'd5, 16'h0000, 2'b00, 16'h0000, 2);

        repeat (4) @(negedge clk);
        check("video_queue_drained", vq.size(), 0);
        check("cpu_queue_drained", cq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
